keypad_scan_encoder: RTL and testbench

Scans a 4x4 active-low matrix keypad by driving one column low at a time. It debounces the row returns and encodes the pressed key into a 4-bit hex code with a single-cycle valid strobe. It is the input-side counterpart of the board's hex-digit display path: its `key_code` feeds the same 4-bit hex value that the display driver consumes. It also runs the column multiplexing in the reverse direction, reading back through the rows instead of lighting segments.

---
 rtl/keypad_scan_encoder.sv | 164 ++++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_encoder
// Purpose  : 4x4 active-low keypad column scanner with debounced hex encoding.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int                  c_slot_w    = $clog2(SCAN_DIV);
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_DIV - 1);
  localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);
  localparam logic [3:0]          c_deb       = 4'(DEBOUNCE_CNT);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_debounce = 2'd1;
  localparam logic [1:0] c_held     = 2'd2;

  logic [3:0]          r_sync1, r_sync2;
  logic [c_slot_w-1:0] r_slot;
  logic [1:0]          r_col_idx;
  logic                r_acc_hit;
  logic [3:0]          r_acc_code;
  logic                r_res_valid, r_res_hit;
  logic [3:0]          r_res_code;
  logic [1:0]          r_state;
  logic [3:0]          r_cand, r_cnt, r_rc;

  logic       w_row_hit, w_slot_last, w_merge_hit;
  logic [1:0] w_row_idx;
  logic [3:0] w_samp_code, w_merge_code;

  // Lowest low row in the current column gives the lowest code for this slot.
  always_comb begin
    w_row_hit = 1'b0;
    w_row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_sync2[r]) begin
        w_row_hit = 1'b1;
        w_row_idx = 2'(r);
      end
    end
  end

  assign w_slot_last  = (r_slot == c_slot_last);
  assign w_samp_code  = {w_row_idx, r_col_idx};
  assign w_merge_hit  = r_acc_hit | w_row_hit;
  assign w_merge_code = (r_acc_hit && (!w_row_hit || (r_acc_code < w_samp_code)))
                        ? r_acc_code : w_samp_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 4'b1111;
      r_sync2     <= 4'b1111;
      r_slot      <= '0;
      r_col_idx   <= 2'd0;
      col         <= 4'b1110;
      r_acc_hit   <= 1'b0;
      r_acc_code  <= 4'd0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_code  <= 4'd0;
    end else begin
      r_sync1     <= row;
      r_sync2     <= r_sync1;
      r_res_valid <= 1'b0;
      if (w_slot_last) begin
        r_slot    <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        col       <= ~(4'b0001 << (r_col_idx + 2'd1));
        if (r_col_idx == 2'd3) begin
          // Scan end: hand the whole-scan result to the FSM and start afresh.
          r_res_valid <= 1'b1;
          r_res_hit   <= w_merge_hit;
          r_res_code  <= w_merge_code;
          r_acc_hit   <= 1'b0;
          r_acc_code  <= 4'd0;
        end else begin
          r_acc_hit   <= w_merge_hit;
          r_acc_code  <= w_merge_code;
        end
      end else begin
        r_slot <= r_slot + c_slot_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_idle;
      r_cand    <= 4'd0;
      r_cnt     <= 4'd0;
      r_rc      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (r_res_valid) begin
        case (r_state)
          c_idle: begin
            if (r_res_hit) begin
              r_cand <= r_res_code;
              r_cnt  <= 4'd1;
              if (c_deb == 4'd1) begin
                key_code  <= r_res_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_rc      <= 4'd0;
                r_state   <= c_held;
              end else begin
                r_state <= c_debounce;
              end
            end
          end
          c_debounce: begin
            if (!r_res_hit) begin
              r_state <= c_idle;
              r_cnt   <= 4'd0;
            end else if (r_res_code != r_cand) begin
              r_cand <= r_res_code;
              r_cnt  <= 4'd1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              if ((r_cnt + 4'd1) == c_deb) begin
                key_code  <= r_cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_rc      <= 4'd0;
                r_state   <= c_held;
              end
            end
          end
          c_held: begin
            // Any key, even a different one, keeps the accepted key held.
            if (r_res_hit) begin
              r_rc <= 4'd0;
            end else if ((r_rc + 4'd1) == c_deb) begin
              key_held <= 1'b0;
              r_rc     <= 4'd0;
              r_cnt    <= 4'd0;
              r_state  <= c_idle;
            end else begin
              r_rc <= r_rc + 4'd1;
            end
          end
          default: r_state <= c_idle;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_encoder
// Purpose  : Directed self-checking bench with a scan-level keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_encoder;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] pressed;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  // Scan-level model: cycle m_cyc counts edges since reset; each scan is one
  // snapshot of the pressed set, and its outcome shows two cycles after its
  // last cycle.
  int  m_cyc = 0, pend_cyc = -1;
  int  m_streak = 0, m_empty = 0, m_last = 0, m_code = 0;
  bit  m_held = 0, p_valid = 0, started = 0;
  logic       exp_valid, exp_held;
  logic [3:0] exp_code;

  always @(posedge clk) begin
    int  code;
    bit  hit;
    if (rst) begin
      m_cyc = 0; pend_cyc = -1; m_streak = 0; m_empty = 0; m_last = 0;
      m_code = 0; m_held = 0; p_valid = 0; started = 1;
      exp_valid = 0; exp_code = 0; exp_held = 0;
    end else begin
      exp_valid = 0;
      if (m_cyc == pend_cyc) begin
        exp_valid = p_valid;
        exp_code  = 4'(m_code);
        exp_held  = m_held;
      end
      if (m_cyc % SCAN == SCAN - 1) begin
        hit = 0; code = 0;
        for (int k = 15; k >= 0; k--)
          if (pressed[k]) begin hit = 1; code = k; end
        p_valid = 0;
        if (!m_held) begin
          if (hit) begin
            m_streak = (m_streak > 0 && code == m_last) ? m_streak + 1 : 1;
            m_last = code;
            if (m_streak == DB) begin
              m_held = 1; m_code = code; p_valid = 1; m_empty = 0; m_streak = 0;
            end
          end else m_streak = 0;
        end else begin
          if (hit) m_empty = 0;
          else begin
            m_empty++;
            if (m_empty == DB) begin m_held = 0; m_empty = 0; end
          end
        end
        pend_cyc = m_cyc + 1;
      end
      m_cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ecol;
    if (started) begin
      ecol = ~(4'b0001 << ((m_cyc / SD) % 4));
      check("col", 32'(col), 32'(ecol));
      check("key_valid", 32'(key_valid), 32'(exp_valid));
      check("key_code", 32'(key_code), 32'(exp_code));
      check("key_held", 32'(key_held), 32'(exp_held));
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic goto(input int c);
    int guard = 0;
    while (m_cyc != c && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (m_cyc != c) begin
      bad++;
      $display("FAIL goto: reached cycle %0d, required %0d", m_cyc, c);
    end
  endtask

  initial begin
    rst = 1'b1;
    pressed = 16'h0;
    pressed[6] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst col", 32'(col), 32'h0000000e);
    check("rst code", 32'(key_code), 32'd0);
    check("rst valid", 32'(key_valid), 32'd0);
    check("rst held", 32'(key_held), 32'd0);
    rst = 1'b0;

    goto(4);  check("col@4", 32'(col), 32'h0000000d);
    goto(8);  check("col@8", 32'(col), 32'h0000000b);
    goto(12); check("col@12", 32'(col), 32'h00000007);
    goto(16); check("col@16", 32'(col), 32'h0000000e);
    goto(32); check("no early pulse", 32'(key_valid), 32'd0);
    goto(33);
    check("press6 valid", 32'(key_valid), 32'd1);
    check("press6 code", 32'(key_code), 32'd6);
    check("press6 held", 32'(key_held), 32'd1);
    goto(48); pressed = 16'h0;
    goto(80); check("release held@80", 32'(key_held), 32'd1);
    goto(81); check("release held@81", 32'(key_held), 32'd0);
    check("pulses after single", 32'(pulses), 32'd1);

    // One full scan of key 6 only: never accepted.
    goto(96);  pressed[6] = 1'b1;
    goto(112); pressed = 16'h0;
    goto(160);
    check("bounce pulses", 32'(pulses), 32'd1);
    check("bounce held", 32'(key_held), 32'd0);

    pressed[3] = 1'b1; pressed[9] = 1'b1;
    goto(193);
    check("multi valid", 32'(key_valid), 32'd1);
    check("multi code", 32'(key_code), 32'd3);
    goto(208); pressed = 16'h0;
    goto(256);
    check("multi released", 32'(key_held), 32'd0);

    pressed[5] = 1'b1;
    goto(289);
    check("key5 valid", 32'(key_valid), 32'd1);
    check("key5 code", 32'(key_code), 32'd5);
    goto(304); pressed[0] = 1'b1;
    goto(352);
    check("extra code", 32'(key_code), 32'd5);
    check("extra pulses", 32'(pulses), 32'd3);
    check("extra held", 32'(key_held), 32'd1);
    pressed = 16'h0;
    goto(384); check("both held@384", 32'(key_held), 32'd1);
    goto(385); check("both held@385", 32'(key_held), 32'd0);

    goto(400); pressed[10] = 1'b1;
    goto(433);
    check("keyA valid", 32'(key_valid), 32'd1);
    check("keyA code", 32'(key_code), 32'd10);
    goto(440);
    rst = 1'b1;
    @(negedge clk);
    check("midrst col", 32'(col), 32'h0000000e);
    check("midrst code", 32'(key_code), 32'd0);
    check("midrst held", 32'(key_held), 32'd0);
    check("midrst valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    check("midrst pulses", 32'(pulses), 32'd4);
    goto(33);
    check("keyA again valid", 32'(key_valid), 32'd1);
    check("keyA again code", 32'(key_code), 32'd10);
    goto(40);
    check("final pulses", 32'(pulses), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
